// File: rtl/dii_demux_multi.sv
// N-way DII worm demultiplexer: header flit destination ID (data[9:0]) selects an output via a
// runtime ID table, body flits follow the header's output; a single hold register drives all lanes.
module dii_demux_multi #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OUT     = 3,
  parameter int DEFAULT_OUT = NUM_OUT - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [10*NUM_OUT-1:0]         route_id,
  input  logic [NUM_OUT-1:0]            route_en,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_last,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH*NUM_OUT-1:0] out_data,
  output logic [NUM_OUT-1:0]            out_last,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready
);

  localparam int SW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  generate
    if (NUM_OUT < 2 || NUM_OUT > 8 || DEFAULT_OUT < 0 || DEFAULT_OUT >= NUM_OUT) begin : g_bad_params
      $error("dii_demux_multi: NUM_OUT must be 2..8 and DEFAULT_OUT < NUM_OUT");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_WORM} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SW-1:0]         r_wsel;
  logic [SW-1:0]         w_wsel_next;
  logic                  r_hv;
  logic [DATA_WIDTH-1:0] r_hdata;
  logic                  r_hlast;
  logic [SW-1:0]         r_hsel;

  logic [SW-1:0]         w_lookup;
  logic [SW-1:0]         w_sel;
  logic                  w_out_rdy;
  logic                  w_accept;

  // Scan from the top down so the lowest matching entry wins.
  always_comb begin
    w_lookup = SW'(DEFAULT_OUT);
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (route_en[i] && (route_id[10*i +: 10] == in_data[9:0])) begin
        w_lookup = SW'(i);
      end
    end
  end

  assign w_out_rdy = out_ready[r_hsel];
  assign in_ready  = !r_hv || w_out_rdy;
  assign w_accept  = in_valid && in_ready;
  assign w_sel     = (r_state == S_IDLE) ? w_lookup : r_wsel;

  always_comb begin
    w_state_next = r_state;
    w_wsel_next  = r_wsel;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_wsel_next = w_lookup;
          if (!in_last) begin
            w_state_next = S_WORM;
          end
        end
        S_WORM: begin
          if (in_last) begin
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wsel  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wsel  <= w_wsel_next;
    end
  end

  // Accept and drain in the same cycle simply overwrites the hold, keeping it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hv    <= 1'b0;
      r_hdata <= '0;
      r_hlast <= 1'b0;
      r_hsel  <= '0;
    end else if (w_accept) begin
      r_hv    <= 1'b1;
      r_hdata <= in_data;
      r_hlast <= in_last;
      r_hsel  <= w_sel;
    end else if (r_hv && w_out_rdy) begin
      r_hv    <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
      assign out_valid[gi]                          = r_hv && (r_hsel == SW'(gi));
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH]  = r_hdata;
      assign out_last[gi]                           = r_hlast;
    end
  endgenerate

endmodule

// File: tb/tb_dii_demux_multi.sv
// Directed table-driven bench for dii_demux_multi (NUM_OUT=3, DATA_WIDTH=16, DEFAULT_OUT=2).
module tb_dii_demux_multi;

  logic        clk;
  logic        rst;
  logic [29:0] route_id;
  logic [2:0]  route_en;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] out_data;
  logic [2:0]  out_last;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;

  int n_cmp = 0;
  int n_err = 0;

  dii_demux_multi #(.DATA_WIDTH(16), .NUM_OUT(3), .DEFAULT_OUT(2)) dut (
    .clk(clk), .rst(rst), .route_id(route_id), .route_en(route_en),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic        vld;
    logic [2:0]  rdy;
    logic [29:0] rid;
    logic [2:0]  ren;
    logic        exp_ir;
    logic [2:0]  exp_ov;
    logic [15:0] exp_od;
    logic        exp_ol;
  } vec_t;

  localparam logic [29:0] T0 = {10'h020, 10'h007, 10'h005};
  localparam logic [29:0] T3 = {10'h020, 10'h005, 10'h005};
  localparam logic [29:0] T5 = {10'h020, 10'h033, 10'h005};

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [2:0] exp_ov,
                           input logic [15:0] exp_od, input logic exp_ol);
    chk({tag, " out_valid"}, {29'd0, out_valid}, {29'd0, exp_ov});
    for (int k = 0; k < 3; k++) begin
      if (exp_ov[k]) begin
        chk({tag, " out_data"}, {16'd0, out_data[16*k +: 16]}, {16'd0, exp_od});
        chk({tag, " out_last"}, {31'd0, out_last[k]}, {31'd0, exp_ol});
      end
    end
  endtask

  initial begin
    // d, last, vld, rdy, table, en | in_ready, out_valid, out_data, out_last
    // Test 1: 3-flit worm to out 1, accept/drain overlap every cycle
    vecs[0]  = '{16'h0007, 1'b0, 1'b1, 3'b111, T0, 3'b011, 1'b1, 3'b010, 16'h0007, 1'b0};
    vecs[1]  = '{16'h1234, 1'b0, 1'b1, 3'b111, T0, 3'b011, 1'b1, 3'b010, 16'h1234, 1'b0};
    vecs[2]  = '{16'h5678, 1'b1, 1'b1, 3'b111, T0, 3'b011, 1'b1, 3'b010, 16'h5678, 1'b1};
    // Test 2: miss goes to default output; idle cycle drains hold
    vecs[3]  = '{16'h0123, 1'b1, 1'b1, 3'b111, T0, 3'b011, 1'b1, 3'b100, 16'h0123, 1'b1};
    vecs[4]  = '{16'h0000, 1'b0, 1'b0, 3'b111, T0, 3'b011, 1'b1, 3'b000, 16'h0000, 1'b0};
    // Test 3: duplicate IDs -> lowest enabled entry wins
    vecs[5]  = '{16'h0005, 1'b1, 1'b1, 3'b111, T3, 3'b011, 1'b1, 3'b001, 16'h0005, 1'b1};
    vecs[6]  = '{16'h0005, 1'b1, 1'b1, 3'b111, T3, 3'b010, 1'b1, 3'b010, 16'h0005, 1'b1};
    // Test 4: out 1 stalled 5 cycles mid-worm; body with ID 0x005 stays on out 1
    vecs[7]  = '{16'h0007, 1'b0, 1'b1, 3'b111, T0, 3'b011, 1'b1, 3'b010, 16'h0007, 1'b0};
    vecs[8]  = '{16'hA005, 1'b0, 1'b1, 3'b101, T0, 3'b011, 1'b0, 3'b010, 16'h0007, 1'b0};
    vecs[9]  = '{16'hA005, 1'b0, 1'b1, 3'b101, T0, 3'b011, 1'b0, 3'b010, 16'h0007, 1'b0};
    vecs[10] = '{16'hA005, 1'b0, 1'b1, 3'b101, T0, 3'b011, 1'b0, 3'b010, 16'h0007, 1'b0};
    vecs[11] = '{16'hA005, 1'b0, 1'b1, 3'b101, T0, 3'b011, 1'b0, 3'b010, 16'h0007, 1'b0};
    vecs[12] = '{16'hA005, 1'b0, 1'b1, 3'b101, T0, 3'b011, 1'b0, 3'b010, 16'h0007, 1'b0};
    vecs[13] = '{16'hA005, 1'b0, 1'b1, 3'b111, T0, 3'b011, 1'b1, 3'b010, 16'hA005, 1'b0};
    vecs[14] = '{16'hBEEF, 1'b1, 1'b1, 3'b111, T0, 3'b011, 1'b1, 3'b010, 16'hBEEF, 1'b1};
    // Test 5: table change mid-worm; later headers use the new table
    vecs[15] = '{16'h0007, 1'b0, 1'b1, 3'b111, T0, 3'b011, 1'b1, 3'b010, 16'h0007, 1'b0};
    vecs[16] = '{16'h1111, 1'b0, 1'b1, 3'b111, T5, 3'b011, 1'b1, 3'b010, 16'h1111, 1'b0};
    vecs[17] = '{16'h2222, 1'b1, 1'b1, 3'b111, T5, 3'b011, 1'b1, 3'b010, 16'h2222, 1'b1};
    vecs[18] = '{16'h0033, 1'b1, 1'b1, 3'b111, T5, 3'b011, 1'b1, 3'b010, 16'h0033, 1'b1};
    vecs[19] = '{16'h0007, 1'b1, 1'b1, 3'b111, T5, 3'b011, 1'b1, 3'b100, 16'h0007, 1'b1};
    vecs[20] = '{16'h0000, 1'b0, 1'b0, 3'b111, T5, 3'b011, 1'b1, 3'b000, 16'h0000, 1'b0};

    rst       = 1'b1;
    route_id  = T0;
    route_en  = 3'b011;
    in_data   = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 3'b111;

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {29'd0, out_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("post-reset out_valid", {29'd0, out_valid}, 32'd0);
    $display("reset: in_ready=%0b out_valid=%b", in_ready, out_valid);

    for (int i = 0; i < 21; i++) begin
      in_data   = vecs[i].d;
      in_last   = vecs[i].last;
      in_valid  = vecs[i].vld;
      out_ready = vecs[i].rdy;
      route_id  = vecs[i].rid;
      route_en  = vecs[i].ren;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
      @(posedge clk);
      #1;
      chk_lanes($sformatf("v%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_ol);
      $display("v%0d: in=%h last=%0b vld=%0b rdy=%b -> in_ready=%0b out_valid=%b",
               i, vecs[i].d, vecs[i].last, vecs[i].vld, vecs[i].rdy, vecs[i].exp_ir, out_valid);
    end

    // Test 6: reset during flit 2 of a worm; next flit must be decoded as a header
    route_id  = T0;
    route_en  = 3'b011;
    out_ready = 3'b111;
    in_data   = 16'h0007;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    chk_lanes("rst-worm hdr", 3'b010, 16'h0007, 1'b0);
    in_data = 16'hC0DE;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    chk("rst-worm out_valid", {29'd0, out_valid}, 32'd0);
    rst     = 1'b0;
    in_data = 16'h0005;
    in_last = 1'b1;
    #1;
    chk("rst-worm in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk_lanes("rst-worm new hdr", 3'b001, 16'h0005, 1'b1);
    $display("reset mid-worm: new header 0x0005 -> out_valid=%b", out_valid);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("final drain out_valid", {29'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
